program_loader: RTL

- Bus-side writer for the CPU's program-memory load interface (mode/addr/instr/WEN).
- Accepts a byte stream over a valid/ready handshake and writes each byte to consecutive addresses starting at 0, holding the CPU in program mode (mode=1) for the whole load.
- When the load finishes, it releases mode to 0 so the CPU runs.
- Replaces hand-driven memory loading; sits between a host byte source (UART receiver or bench) and the cpu block.

---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake between a host byte source and the program loader.
//   byte_valid : source has a byte on byte_data
//   byte_data  : stream byte
//   byte_last  : byte_data is the final byte of the program
//   byte_ready : loader accepts the byte on this cycle's rising edge
// master = byte source, slave = loader.
interface program_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              byte_last;
    logic              byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: writes a byte stream into CPU program memory at addresses
// 0,1,2,... while holding the CPU in program mode, then releases it to run.
// Ports:
//   CLK, nRST      : clock, asynchronous active-low reset
//   start          : one-cycle load request (ignored while busy)
//   abort          : cancel an in-progress load
//   bus            : byte stream (slave side), byte_ready is registered
//   mode           : 1 = CPU program mode, 0 = run
//   addr/instr/WEN : program-memory write port
//   busy/done/err  : load status (done/err are levels for the last load)
module program_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              abort,
    program_loader_if.slave   bus,
    output logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instr,
    output logic              WEN,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        WRITE,
        HOLD,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              last_q, last_d;
    logic              mode_d, wen_d, busy_d, done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] instr_d;

    assign bus.byte_ready = ready_q;

    // State and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            mode    <= 1'b0;
            addr    <= '0;
            instr   <= '0;
            WEN     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            mode    <= mode_d;
            addr    <= addr_d;
            instr   <= instr_d;
            WEN     <= wen_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        mode_d  = mode;
        addr_d  = addr;
        instr_d = instr;
        wen_d   = 1'b0;
        busy_d  = busy;
        done_d  = done;
        err_d   = err;

        if (abort && (state_q != IDLE)) begin
            // Abort drops WEN on the next edge, so a write in flight stays one cycle
            state_d = IDLE;
            mode_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WAIT_BYTE;
                        mode_d  = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = '0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (bus.byte_valid && ready_q) begin
                        instr_d = bus.byte_data;
                        last_d  = bus.byte_last;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    state_d = WRITE;
                    wen_d   = 1'b1;
                end
                WRITE: begin
                    state_d = HOLD;
                end
                HOLD: begin
                    if (last_q) begin
                        state_d = RELEASE;
                        err_d   = 1'b0;
                    end else if (addr == ADDR_MAX) begin
                        // Memory full without a last byte: overflow
                        state_d = RELEASE;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = addr + ADDR_W'(1);
                        state_d = WAIT_BYTE;
                    end
                end
                RELEASE: begin
                    state_d = IDLE;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ready_d = (state_d == WAIT_BYTE);
    end

endmodule
